decimal_binary: RTL and testbench

DECIMAL_BINARY -- requirements
Module: decimal_binary

---
 rtl/decimal_binary.sv | 133 +++++++++++++
 tb/tb_decimal_binary.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decimal_binary.sv
// Keypad entry to binary: up to two integer digits plus an optional .0/.5 half,
// committed on enter with a one-cycle data_valid pulse; rejected keys pulse error.
module decimal_binary (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] data,
  output logic       decimal,
  output logic       data_valid,
  output logic       error,
  output logic [1:0] digit_count
);

  localparam logic [3:0] KEY_POINT = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  typedef enum logic [2:0] {IDLE, INT, FRAC, FRAC_DONE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [6:0] acc_q, acc_d;
  logic       half_q, half_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       dec_q, dec_d;
  logic       err_q, err_d;

  logic       is_digit;
  logic [6:0] acc_x10;
  logic [6:0] key_ext;

  assign is_digit = (key_code <= 4'd9);
  assign key_ext  = {3'b000, key_code};
  // acc never exceeds 9 when multiplied, so 7 bits hold the result
  assign acc_x10  = {acc_q[3:0], 3'b000} + {acc_q[5:0], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= 7'd0;
      half_q  <= 1'b0;
      cnt_q   <= 2'd0;
      data_q  <= 8'd0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dec_d   = dec_q;
    err_d   = 1'b0;

    if (state_q == EMIT) begin
      // strobes landing here are dropped silently
      state_d = IDLE;
      acc_d   = 7'd0;
      half_d  = 1'b0;
      cnt_d   = 2'd0;
    end else if (key_valid) begin
      if (key_code == KEY_CLEAR) begin
        state_d = IDLE;
        acc_d   = 7'd0;
        half_d  = 1'b0;
        cnt_d   = 2'd0;
      end else if (key_code > KEY_CLEAR) begin
        err_d = 1'b1;
      end else if (key_code == KEY_ENTER) begin
        if (state_q == IDLE) begin
          err_d = 1'b1;
        end else begin
          data_d  = {1'b0, acc_q};
          dec_d   = half_q;
          state_d = EMIT;
        end
      end else if (key_code == KEY_POINT) begin
        if (state_q == IDLE) begin
          acc_d   = 7'd0;
          state_d = FRAC;
        end else if (state_q == INT) begin
          state_d = FRAC;
        end else begin
          err_d = 1'b1;
        end
      end else if (is_digit) begin
        case (state_q)
          IDLE: begin
            acc_d   = key_ext;
            cnt_d   = 2'd1;
            state_d = INT;
          end
          INT: begin
            if (cnt_q == 2'd1) begin
              acc_d = acc_x10 + key_ext;
              cnt_d = 2'd2;
            end else begin
              err_d = 1'b1;
            end
          end
          FRAC: begin
            if (key_code == 4'd5 || key_code == 4'd0) begin
              half_d  = (key_code == 4'd5);
              state_d = FRAC_DONE;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  assign data        = data_q;
  assign decimal     = dec_q;
  assign data_valid  = (state_q == EMIT);
  assign error       = err_q;
  assign digit_count = cnt_q;

endmodule

// File: tb/tb_decimal_binary.sv
// Bench for decimal_binary: directed keypad sequences then random strobes,
// each cycle compared against an entry-level model.
module tb_decimal_binary;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] data;
  logic       decimal;
  logic       data_valid;
  logic       error;
  logic [1:0] digit_count;

  decimal_binary dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .data        (data),
    .decimal     (decimal),
    .data_valid  (data_valid),
    .error       (error),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model of the entry in progress, kept as typed characters rather than states
  int m_ndig, m_ival, m_frac, m_data;
  bit m_pt, m_emit, m_dec, m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic void clear_entry();
    m_ndig = 0; m_ival = 0; m_frac = -1; m_pt = 1'b0;
  endfunction

  function automatic void model_reset();
    clear_entry();
    m_data = 0; m_dec = 1'b0; m_emit = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_update(input bit kv, input int kc);
    bit e = 1'b0;
    if (m_emit) begin
      m_emit = 1'b0;
      clear_entry();
    end else if (kv) begin
      if (kc <= 9) begin
        if (!m_pt) begin
          if (m_ndig < 2) begin m_ival = m_ival * 10 + kc; m_ndig++; end
          else e = 1'b1;
        end else if (m_frac < 0 && (kc == 0 || kc == 5)) m_frac = kc;
        else e = 1'b1;
      end else if (kc == 10) begin
        if (m_pt) e = 1'b1; else m_pt = 1'b1;
      end else if (kc == 11) begin
        if (m_ndig == 0 && !m_pt) e = 1'b1;
        else begin m_data = m_ival; m_dec = (m_frac == 5); m_emit = 1'b1; end
      end else if (kc == 12) begin
        clear_entry();
      end else e = 1'b1;
    end
    m_err = e;
  endfunction

  task automatic check_all();
    chk("data", data, m_data);
    chk("decimal", decimal, m_dec);
    chk("data_valid", data_valid, m_emit);
    chk("error", error, m_err);
    chk("digit_count", digit_count, m_ndig);
  endtask

  task automatic step(input bit kv, input int kc);
    key_valid = kv;
    key_code  = kc[3:0];
    @(posedge clk);
    model_update(kv, kc);
    #1;
    check_all();
  endtask

  task automatic key(input int kc);
    step(1'b1, kc);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_data", data, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", digit_count, 0);
    chk("rst_dec", decimal, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r, kc;
    reset = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    model_reset();
    #12;
    chk("rst_data", data, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", digit_count, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 0);

    // 2 7 . 5 enter -> 27.5
    key(2); key(7); key(10); key(5); key(11);
    chk("k27_dv", data_valid, 1);
    chk("k27_data", data, 27);
    chk("k27_dec", decimal, 1);
    step(1'b0, 0);
    chk("k27_dv_low", data_valid, 0);

    // 4 enter, then . 0 enter
    key(4); key(11);
    chk("k4_data", data, 4);
    step(1'b0, 0);
    key(10); key(0); key(11);
    chk("k0_data", data, 0);
    chk("k0_dec", decimal, 0);
    step(1'b0, 0);

    // 9 9 3 enter -> error after 3, commit 99
    key(9); key(9); key(3);
    chk("k993_err", error, 1);
    key(11);
    chk("k99_data", data, 99);
    step(1'b0, 0);

    // 1 . 7 5 enter -> error after 7 only, commit 1.5
    key(1); key(10); key(7);
    chk("k17_err", error, 1);
    key(5);
    chk("k15_noerr", error, 0);
    key(11);
    chk("k15_data", data, 1);
    chk("k15_dec", decimal, 1);
    // strobe landing in EMIT is dropped without error
    key(3);
    chk("emit_drop_cnt", digit_count, 0);

    // 3 clear enter -> one error, previous value kept
    key(3); key(12); key(11);
    chk("clr_err", error, 1);
    chk("clr_keep", data, 1);
    step(1'b0, 0);

    // 6 5 then reset -> clean; next 1 enter commits 1
    key(6); key(5);
    do_reset();
    key(1); key(11);
    chk("post_rst_data", data, 1);
    step(1'b0, 0);

    // random keys against the model, with occasional resets
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10) kc = r;
      else if (r < 13) kc = 10;
      else if (r < 17) kc = 11;
      else if (r < 18) kc = 12;
      else kc = 13 + $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, kc);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
